// File: rtl/prefetch_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// prefetch_queue : 6-byte in-order code prefetch buffer between a byte ROM and the core.  Rev 1.0
// ---------------------------------------------------------------------------
module prefetch_queue #(
   parameter int          DEPTH    = 6,
   parameter logic [15:0] RESET_CS = 16'hFFFF,
   parameter logic [15:0] RESET_IP = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        rom_en,
   output logic [19:0] rom_addr,
   input  logic [7:0]  rom_data,
   input  logic        fetch_hold,
   input  logic        flush,
   input  logic [15:0] flush_cs,
   input  logic [15:0] flush_ip,
   input  logic [2:0]  consume,
   output logic [47:0] q_bytes,
   output logic [2:0]  q_count,
   output logic [15:0] ip_out
);

   logic [15:0] cs_q;
   logic [15:0] fetch_ip_q;
   logic [15:0] ip_q;
   logic [2:0]  count_q;
   logic        pend_q;
   logic [7:0]  mem_q [DEPTH];

   logic [7:0]  mem_d [DEPTH];
   logic [2:0]  count_d;
   logic [2:0]  cons_eff;
   logic [2:0]  base;
   logic [3:0]  occ;

   // Issue is gated on bytes held plus the one in flight, so the array can never overflow.
   assign occ      = {1'b0, count_q} + {3'b000, pend_q};
   assign rom_en   = rst & ~flush & ~fetch_hold & (occ < 4'(DEPTH));
   assign rom_addr = {cs_q, 4'h0} + {4'h0, fetch_ip_q};

   assign cons_eff = (consume > count_q) ? count_q : consume;
   assign base     = count_q - cons_eff;
   assign count_d  = base + {2'b00, pend_q};

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = mem_q[i];
         for (int s = 0; s < DEPTH; s++) begin
            if ({1'b0, 3'(i)} + {1'b0, cons_eff} == 4'(s)) begin
               mem_d[i] = mem_q[s];
            end
         end
         // Returning byte lands right behind the surviving bytes.
         if (pend_q && (base == 3'(i))) begin
            mem_d[i] = rom_data;
         end
      end
   end

   always_comb begin
      q_bytes = '0;
      for (int i = 0; i < DEPTH; i++) begin
         q_bytes[8*i +: 8] = mem_q[i];
      end
   end

   assign q_count = rst ? count_q : 3'd0;
   assign ip_out  = rst ? ip_q : RESET_IP;

   always_ff @(posedge clk) begin
      if (!rst) begin
         count_q    <= 3'd0;
         pend_q     <= 1'b0;
         cs_q       <= RESET_CS;
         fetch_ip_q <= RESET_IP;
         ip_q       <= RESET_IP;
      end else if (flush) begin
         count_q    <= 3'd0;
         pend_q     <= 1'b0;
         cs_q       <= flush_cs;
         fetch_ip_q <= flush_ip;
         ip_q       <= flush_ip;
      end else begin
         mem_q   <= mem_d;
         count_q <= count_d;
         pend_q  <= rom_en;
         if (rom_en) begin
            fetch_ip_q <= fetch_ip_q + 16'd1;
         end
         ip_q <= ip_q + {13'd0, cons_eff};
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_prefetch_queue.sv
`default_nettype none
// tb_prefetch_queue : directed test-plan steps plus random traffic against a byte-queue reference model.
module tb_prefetch_queue;

   localparam logic [15:0] RESET_CS = 16'hFFFF;
   localparam logic [15:0] RESET_IP = 16'h0000;

   logic        clk;
   logic        rst;
   logic        rom_en;
   logic [19:0] rom_addr;
   logic [7:0]  rom_data;
   logic        fetch_hold;
   logic        flush;
   logic [15:0] flush_cs;
   logic [15:0] flush_ip;
   logic [2:0]  consume;
   logic [47:0] q_bytes;
   logic [2:0]  q_count;
   logic [15:0] ip_out;

   int total = 0;
   int bad   = 0;

   prefetch_queue #(.DEPTH(6), .RESET_CS(RESET_CS), .RESET_IP(RESET_IP)) dut (
      .clk(clk), .rst(rst), .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
      .fetch_hold(fetch_hold), .flush(flush), .flush_cs(flush_cs), .flush_ip(flush_ip),
      .consume(consume), .q_bytes(q_bytes), .q_count(q_count), .ip_out(ip_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] rom_fn(input logic [19:0] a);
      if (a >= 20'hFFFF0 && a <= 20'hFFFF5) return 8'h11 + 8'(a - 20'hFFFF0);
      return a[7:0] ^ {a[11:8], a[15:12]} ^ {a[19:16], 4'h5};
   endfunction

   // Byte ROM: data one cycle after the strobe, junk otherwise.
   initial rom_data = 8'h00;
   always @(posedge clk) rom_data <= rom_en ? rom_fn(rom_addr) : 8'($urandom);

   // Reference model: a byte queue plus the architectural pointers.
   logic [7:0]  mq [$];
   logic [15:0] m_cs = RESET_CS, m_fip = RESET_IP, m_ip = RESET_IP;
   logic        m_pend = 1'b0;
   logic [19:0] m_paddr = '0;
   logic [7:0]  n_q [$];
   logic [15:0] n_cs, n_fip, n_ip;
   logic        n_pend;
   logic [19:0] n_paddr;
   logic        exp_en;
   logic [19:0] exp_addr;

   task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_check();
      exp_en   = rst & ~flush & ~fetch_hold & ((mq.size() + int'(m_pend)) < 6);
      exp_addr = {m_cs, 4'h0} + {4'h0, m_fip};
      chk("rom_en", 48'(rom_en), 48'(exp_en));
      chk("q_count", 48'(q_count), rst ? 48'(mq.size()) : 48'd0);
      chk("ip_out", 48'(ip_out), rst ? 48'(m_ip) : 48'(RESET_IP));
      if (rst) begin
         chk("rom_addr", 48'(rom_addr), 48'(exp_addr));
         for (int k = 0; k < mq.size(); k++)
            chk($sformatf("q_byte%0d", k), 48'(q_bytes[8*k +: 8]), 48'(mq[k]));
         if (mq.size() > 0)
            chk("head_at_ip", 48'(q_bytes[7:0]), 48'(rom_fn({m_cs, 4'h0} + {4'h0, m_ip})));
      end
   endtask

   task automatic model_next();
      int ce;
      n_q = mq; n_cs = m_cs; n_fip = m_fip; n_ip = m_ip; n_pend = m_pend; n_paddr = m_paddr;
      if (!rst) begin
         n_q = {}; n_pend = 1'b0; n_cs = RESET_CS; n_fip = RESET_IP; n_ip = RESET_IP;
      end else if (flush) begin
         n_q = {}; n_pend = 1'b0; n_cs = flush_cs; n_fip = flush_ip; n_ip = flush_ip;
      end else begin
         ce = (int'(consume) > mq.size()) ? mq.size() : int'(consume);
         repeat (ce) void'(n_q.pop_front());
         if (m_pend) n_q.push_back(rom_fn(m_paddr));
         n_pend  = exp_en;
         n_paddr = exp_addr;
         if (exp_en) n_fip = m_fip + 16'd1;
         n_ip = m_ip + 16'(ce);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      model_check();
      model_next();
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
      mq = n_q; m_cs = n_cs; m_fip = n_fip; m_ip = n_ip; m_pend = n_pend; m_paddr = n_paddr;
   endtask

   task automatic cyc();
      tick();
      adv();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; fetch_hold = 1'b0; flush = 1'b0; flush_cs = '0; flush_ip = '0; consume = '0;
      cyc(); cyc();

      // Fill from reset vector
      rst = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("fill_addr", 48'(rom_addr), 48'(20'hFFFF0 + 20'(i)));
         chk("fill_en", 48'(rom_en), 48'd1);
         adv();
      end
      cyc();
      tick();
      chk("full_count", 48'(q_count), 48'd6);
      chk("full_en", 48'(rom_en), 48'd0);
      chk("full_bytes", q_bytes, 48'h161514131211);
      adv();

      // Consume 2, refill
      consume = 3'd2;
      cyc();
      consume = 3'd0;
      tick();
      chk("c2_count", 48'(q_count), 48'd4);
      chk("c2_ip", 48'(ip_out), 48'h0002);
      chk("c2_head", 48'(q_bytes[7:0]), 48'h13);
      chk("refill_addr0", 48'(rom_addr), 48'hFFFF6);
      adv();
      tick();
      chk("refill_addr1", 48'(rom_addr), 48'hFFFF7);
      adv();
      cyc(); cyc();

      // Steady consume 1 per cycle
      consume = 3'd1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (i >= 3) chk("steady_count", 48'(q_count), 48'd4);
         adv();
      end

      // Flush with fetch in flight
      consume = 3'd0; flush = 1'b1; flush_cs = 16'h1000; flush_ip = 16'hFFFE;
      tick();
      chk("flush_en", 48'(rom_en), 48'd0);
      adv();
      flush = 1'b0;
      tick();
      chk("flush_count", 48'(q_count), 48'd0);
      chk("flush_ip", 48'(ip_out), 48'hFFFE);
      chk("flush_addr0", 48'(rom_addr), 48'h1FFFE);
      adv();
      tick(); chk("flush_addr1", 48'(rom_addr), 48'h1FFFF); adv();
      tick(); chk("flush_addr2", 48'(rom_addr), 48'h10000); adv();
      cyc();

      // Hold with 3 queued and one pending
      fetch_hold = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (i == 0) chk("hold_start_count", 48'(q_count), 48'd3);
         if (i > 0) chk("hold_count", 48'(q_count), 48'd4);
         chk("hold_en", 48'(rom_en), 48'd0);
         adv();
      end
      fetch_hold = 1'b0; consume = 3'd7;
      tick();
      chk("resume_en", 48'(rom_en), 48'd1);
      adv();
      consume = 3'd0;
      tick();
      chk("clamp_count", 48'(q_count), 48'd0);
      chk("clamp_ip", 48'(ip_out), 48'h0002);
      adv();
      cyc();

      // Reset with a pending fetch
      rst = 1'b0;
      tick();
      chk("rst_en0", 48'(rom_en), 48'd0);
      adv();
      tick();
      chk("rst_count", 48'(q_count), 48'd0);
      chk("rst_en1", 48'(rom_en), 48'd0);
      adv();
      rst = 1'b1;
      tick();
      chk("rst_addr", 48'(rom_addr), 48'hFFFF0);
      adv();
      for (int i = 0; i < 8; i++) cyc();

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         rst        = ($urandom_range(0, 99) != 0);
         flush      = ($urandom_range(0, 19) == 0);
         fetch_hold = ($urandom_range(0, 4) == 0);
         consume    = 3'($urandom_range(0, 7));
         flush_cs   = 16'($urandom);
         flush_ip   = 16'($urandom);
         cyc();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
